// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: RAM word/state types and the arbiter FSM encoding.
package memory_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_D = 2'd1,
    GRANT_I = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Cache-side and RAM-side bus of the memory arbiter; master is the arbiter, slave is caches + RAM.
interface memory_arbiter_if #(
  parameter int CPUS = 2
);
  import memory_arbiter_pkg::*;

  // Handshake: a request (xREN/xWEN) is held until its xwait drops to 0 for one cycle,
  // which marks completion (xload valid for reads); the RAM completes when ramstate==ACCESS.
  logic      [CPUS-1:0] iREN;
  word_t     [CPUS-1:0] iaddr;
  logic      [CPUS-1:0] iwait;
  word_t     [CPUS-1:0] iload;
  logic      [CPUS-1:0] dREN;
  logic      [CPUS-1:0] dWEN;
  word_t     [CPUS-1:0] daddr;
  word_t     [CPUS-1:0] dstore;
  logic      [CPUS-1:0] dwait;
  word_t     [CPUS-1:0] dload;
  logic                 ramREN;
  logic                 ramWEN;
  word_t                ramaddr;
  word_t                ramstore;
  word_t                ramload;
  ramstate_t            ramstate;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/memory_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  always_comb begin
    int   c;
    logic found;
    c     = 0;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Sole RAM master: arbitrates per-core icache/dcache word accesses, data before instruction,
// round-robin within each class, dcache grant held for a whole BURST-word block.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter  int CPUS  = 2,
  parameter  int BURST = 2,
  localparam int IW    = (CPUS > 1) ? $clog2(CPUS) : 1,
  localparam int BW    = $clog2(BURST + 1)
) (
  input  logic                  CLK,
  input  logic                  n_rst,
  memory_arbiter_if.master      bus,
  output arb_state_t            dbg_state,
  output logic                  dbg_err,
  output logic [IW-1:0]         dbg_rr_d,
  output logic [IW-1:0]         dbg_rr_i
);

  arb_state_t      state;
  logic [IW-1:0]   gidx;
  logic [BW-1:0]   beat;
  logic [IW-1:0]   rr_d;
  logic [IW-1:0]   rr_i;
  logic            err;

  logic [CPUS-1:0] d_req;
  logic [CPUS-1:0] d_gnt;
  logic [CPUS-1:0] i_gnt;
  logic [IW-1:0]   d_idx;
  logic [IW-1:0]   i_idx;
  logic            live;
  logic            done;

  logic [CPUS-1:0] iwait_c;
  logic [CPUS-1:0] dwait_c;
  word_t [CPUS-1:0] iload_c;
  word_t [CPUS-1:0] dload_c;

  assign d_req = bus.dREN | bus.dWEN;

  rr_arbiter #(.N(CPUS)) u_rr_d (.req(d_req),    .ptr(rr_d), .grant(d_gnt), .idx(d_idx));
  rr_arbiter #(.N(CPUS)) u_rr_i (.req(bus.iREN), .ptr(rr_i), .grant(i_gnt), .idx(i_idx));

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (int'(i) == CPUS - 1) ? '0 : i + 1'b1;
  endfunction

  // RAM side and completions follow the registered grant; a dropped request drives nothing.
  always_comb begin
    live         = 1'b0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    iwait_c      = '1;
    dwait_c      = '1;
    iload_c      = '0;
    dload_c      = '0;
    if (state == GRANT_D) begin
      live = d_req[gidx];
    end else if (state == GRANT_I) begin
      live = bus.iREN[gidx];
    end
    done = live && (bus.ramstate == ACCESS);
    if (live && state == GRANT_D) begin
      bus.ramaddr = bus.daddr[gidx];
      if (bus.dWEN[gidx]) begin
        bus.ramWEN   = 1'b1;
        bus.ramstore = bus.dstore[gidx];
      end else begin
        bus.ramREN = 1'b1;
      end
      if (done) begin
        dwait_c[gidx] = 1'b0;
        if (!bus.dWEN[gidx]) dload_c[gidx] = bus.ramload;
      end
    end else if (live && state == GRANT_I) begin
      bus.ramaddr = bus.iaddr[gidx];
      bus.ramREN  = 1'b1;
      if (done) begin
        iwait_c[gidx] = 1'b0;
        iload_c[gidx] = bus.ramload;
      end
    end
  end

  assign bus.iwait = iwait_c;
  assign bus.dwait = dwait_c;
  assign bus.iload = iload_c;
  assign bus.dload = dload_c;

  always_ff @(posedge CLK or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      gidx  <= '0;
      beat  <= '0;
      rr_d  <= '0;
      rr_i  <= '0;
      err   <= 1'b0;
    end else begin
      if (state != IDLE && live && bus.ramstate == ERROR) err <= 1'b1;
      case (state)
        IDLE: begin
          if (|d_gnt) begin
            state <= GRANT_D;
            gidx  <= d_idx;
            beat  <= '0;
          end else if (|i_gnt) begin
            state <= GRANT_I;
            gidx  <= i_idx;
          end
        end
        GRANT_D: begin
          if (!live) begin
            state <= IDLE;
            rr_d  <= next_idx(gidx);
          end else if (done) begin
            // Hold the grant until the whole block has moved so beats are never interleaved.
            if (beat == BW'(BURST - 1)) begin
              state <= IDLE;
              beat  <= '0;
              rr_d  <= next_idx(gidx);
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        GRANT_I: begin
          if (!live || done) begin
            state <= IDLE;
            rr_i  <= next_idx(gidx);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;
  assign dbg_err   = err;
  assign dbg_rr_d  = rr_d;
  assign dbg_rr_i  = rr_i;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: bench drives caches and ramstate, RAM reads return addr ^ PAT.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam word_t PAT = 32'hA5A5_0000;

  logic       CLK = 1'b0;
  logic       n_rst;
  arb_state_t dbg_state;
  logic       dbg_err;
  logic       dbg_rr_d;
  logic       dbg_rr_i;

  int errors = 0;
  int checks = 0;
  logic [0:0] exp_q[$];
  word_t      store_tab [2];

  memory_arbiter_if #(.CPUS(2)) bus ();

  memory_arbiter #(.CPUS(2), .BURST(2)) dut (
    .CLK       (CLK),
    .n_rst     (n_rst),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_err   (dbg_err),
    .dbg_rr_d  (dbg_rr_d),
    .dbg_rr_i  (dbg_rr_i)
  );

  always #5 CLK = ~CLK;

  assign bus.ramload = bus.ramaddr ^ PAT;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iREN     = '0;
    bus.iaddr    = '0;
    bus.dREN     = '0;
    bus.dWEN     = '0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramstate = FREE;
  endtask

  task automatic do_reset();
    idle_inputs();
    n_rst = 1'b0;
    repeat (2) @(posedge CLK);
    #3 n_rst = 1'b1;
  endtask

  initial begin
    logic [0:0] e;
    logic [0:0] core;

    // Reset state
    idle_inputs();
    n_rst = 1'b0;
    #12;
    check("rst_iwait",  bus.iwait,  2'b11);
    check("rst_dwait",  bus.dwait,  2'b11);
    check("rst_ren",    bus.ramREN, 0);
    check("rst_wen",    bus.ramWEN, 0);
    check("rst_addr",   bus.ramaddr, 0);
    check("rst_store",  bus.ramstore, 0);
    check("rst_iload",  bus.iload,  0);
    check("rst_dload",  bus.dload,  0);
    check("rst_state",  dbg_state,  IDLE);
    check("rst_rr_d",   dbg_rr_d,   0);
    check("rst_rr_i",   dbg_rr_i,   0);
    check("rst_err",    dbg_err,    0);
    n_rst = 1'b1;
    tick();

    // 1: single fetch, one BUSY then ACCESS
    bus.iREN[0]  = 1'b1;
    bus.iaddr[0] = 32'h0;
    bus.ramstate = BUSY;
    #1 check("t1_idle_ren", bus.ramREN, 0);
    check("t1_idle_iwait", bus.iwait, 2'b11);
    tick();
    check("t1_busy_ren", bus.ramREN, 1);
    check("t1_busy_iwait", bus.iwait, 2'b11);
    check("t1_busy_addr", bus.ramaddr, 32'h0);
    tick();
    bus.ramstate = ACCESS;
    #1 check("t1_done_iwait", bus.iwait, 2'b10);
    check("t1_iload", bus.iload[0], 32'hA5A5_0000);
    tick();
    bus.iREN[0]  = 1'b0;
    bus.ramstate = FREE;
    #1 check("t1_after_ren", bus.ramREN, 0);
    check("t1_after_state", dbg_state, IDLE);
    check("t1_rr_i", dbg_rr_i, 1);

    // 2: data burst on core0 beats a concurrent core1 fetch
    bus.dREN[0]  = 1'b1;
    bus.daddr[0] = 32'h100;
    bus.iREN[1]  = 1'b1;
    bus.iaddr[1] = 32'h40;
    bus.ramstate = ACCESS;
    tick();
    check("t2_b0_ren", bus.ramREN, 1);
    check("t2_b0_addr", bus.ramaddr, 32'h100);
    check("t2_b0_dwait", bus.dwait, 2'b10);
    check("t2_b0_dload", bus.dload[0], 32'hA5A5_0100);
    check("t2_b0_iwait", bus.iwait, 2'b11);
    tick();
    bus.daddr[0] = 32'h104;
    #1 check("t2_b1_addr", bus.ramaddr, 32'h104);
    check("t2_b1_dwait", bus.dwait, 2'b10);
    check("t2_b1_dload", bus.dload[0], 32'hA5A5_0104);
    check("t2_b1_iwait", bus.iwait, 2'b11);
    tick();
    bus.dREN[0] = 1'b0;
    #1 check("t2_gap_state", dbg_state, IDLE);
    check("t2_gap_iwait", bus.iwait, 2'b11);
    check("t2_gap_ren", bus.ramREN, 0);
    tick();
    check("t2_i_iwait", bus.iwait, 2'b01);
    check("t2_i_iload", bus.iload[1], 32'hA5A5_0040);
    check("t2_i_addr", bus.ramaddr, 32'h40);
    tick();
    bus.iREN[1] = 1'b0;
    #1 check("t2_rr_i", dbg_rr_i, 0);
    check("t2_rr_d", dbg_rr_d, 1);

    // 3: both cores write every cycle; bursts alternate 0,0,1,1,...
    do_reset();
    tick();
    store_tab[0] = 32'h1111_0000;
    store_tab[1] = 32'h2222_0000;
    bus.dWEN      = 2'b11;
    bus.daddr[0]  = 32'h500;
    bus.daddr[1]  = 32'h600;
    bus.dstore[0] = store_tab[0];
    bus.dstore[1] = store_tab[1];
    bus.ramstate  = ACCESS;
    exp_q = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 12; k++) begin
      #1;
      check("t3_ren", bus.ramREN, 0);
      check("t3_wen", bus.ramWEN, (k % 3) != 0);
      if (bus.dwait != 2'b11) begin
        core = bus.dwait[0] ? 1'b1 : 1'b0;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
        check("t3_core", core, e);
        check("t3_store", bus.ramstore, store_tab[core]);
      end
      tick();
    end
    check("t3_count", exp_q.size(), 0);
    bus.dWEN = 2'b00;
    #1 check("t3_rr_d", dbg_rr_d, 0);

    // 4: ERROR for three cycles, then ACCESS
    bus.dREN[1]  = 1'b1;
    bus.daddr[1] = 32'h200;
    bus.ramstate = ERROR;
    tick();
    for (int k = 0; k < 3; k++) begin
      check("t4_err_dwait", bus.dwait, 2'b11);
      check("t4_err_ren", bus.ramREN, 1);
      tick();
    end
    check("t4_err_bit", dbg_err, 1);
    bus.ramstate = ACCESS;
    #1 check("t4_done_dwait", bus.dwait, 2'b01);
    check("t4_dload", bus.dload[1], 32'hA5A5_0200);
    tick();
    bus.dREN[1] = 1'b0;
    #1 check("t4_drop_dwait", bus.dwait, 2'b11);
    check("t4_drop_ren", bus.ramREN, 0);
    tick();
    check("t4_idle_dwait", bus.dwait, 2'b11);
    check("t4_state", dbg_state, IDLE);
    check("t4_rr_d", dbg_rr_d, 0);

    // 5: granted dREN drops before ACCESS
    bus.dREN[0]  = 1'b1;
    bus.daddr[0] = 32'h300;
    bus.ramstate = BUSY;
    tick();
    bus.dREN[0] = 1'b0;
    #1 check("t5_ren", bus.ramREN, 0);
    check("t5_wen", bus.ramWEN, 0);
    check("t5_dwait", bus.dwait, 2'b11);
    check("t5_state_g", dbg_state, GRANT_D);
    tick();
    check("t5_state", dbg_state, IDLE);
    check("t5_rr_d", dbg_rr_d, 1);

    // 6: reset in the middle of a burst
    bus.dREN      = 2'b11;
    bus.daddr[0]  = 32'h700;
    bus.daddr[1]  = 32'h800;
    bus.ramstate  = ACCESS;
    tick();
    check("t6_b0_dwait", bus.dwait, 2'b01);
    #2 n_rst = 1'b0;
    #1 check("t6_rst_dwait", bus.dwait, 2'b11);
    check("t6_rst_iwait", bus.iwait, 2'b11);
    check("t6_rst_ren", bus.ramREN, 0);
    check("t6_rst_wen", bus.ramWEN, 0);
    check("t6_rst_state", dbg_state, IDLE);
    check("t6_rst_rr_d", dbg_rr_d, 0);
    #2 n_rst = 1'b1;
    tick();
    check("t6_post_dwait", bus.dwait, 2'b10);
    check("t6_post_addr", bus.ramaddr, 32'h700);
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
